// File: rtl/mole_judge_pkg.sv
// Shared definitions for the whack-a-mole judge: game state encoding, lives width
// and the default button debounce length.
package mole_judge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int LIVES_W          = 4;
  localparam int DEBOUNCE_DEFAULT = 500000;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus level debouncer for one raw button.
// The press pulse appears DEBOUNCE+2 cycles after a clean raw rising edge.
module btn_debounce
  import mole_judge_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  // The counter only runs while the synchronized input disagrees with the accepted
  // level, so any glitch shorter than DEBOUNCE cycles restarts it from zero.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/mole_judge.sv
// Player-side judge: conditions the buttons, scores hits and charges penalties,
// and runs the IDLE/PLAY/PAUSE/OVER game state that freezes the hole FSMs.
module mole_judge
  import mole_judge_pkg::*;
#(
  parameter int N_HOLES  = 4,
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT,
  parameter int LIVES    = 3,
  parameter int SCORE_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_HOLES-1:0] btn,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic [N_HOLES-1:0] mouse,
  input  logic [N_HOLES-1:0] fail,
  output logic [N_HOLES-1:0] hit,
  output logic               keep,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over,
  output logic               playing
);

  localparam int PC_W = $clog2(2 * N_HOLES + 1);

  logic [N_HOLES-1:0] hole_press;
  logic               start_press, pause_press;

  for (genvar g = 0; g < N_HOLES; g++) begin : g_hole
    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .clk(clk), .rst(rst), .raw(btn[g]), .level(), .press(hole_press[g])
    );
  end

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_start (
    .clk(clk), .rst(rst), .raw(start_btn), .level(), .press(start_press)
  );

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_pause (
    .clk(clk), .rst(rst), .raw(pause_btn), .level(), .press(pause_press)
  );

  state_t             state_q, state_d;
  logic [N_HOLES-1:0] fail_q, fail_prev_q, miss;
  logic [N_HOLES-1:0] hits, wrong;
  logic [N_HOLES-1:0] hit_q, hit_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W:0]   score_sum;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [PC_W-1:0]    hit_cnt, pen_cnt;
  logic               keep_q, playing_q, game_over_q;

  always_comb begin
    miss    = fail_q & ~fail_prev_q;
    hits    = hole_press & mouse;
    wrong   = hole_press & ~mouse;
    hit_cnt = '0;
    pen_cnt = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      hit_cnt = hit_cnt + PC_W'(hits[i]);
      pen_cnt = pen_cnt + PC_W'(wrong[i]) + PC_W'(miss[i]);
    end
    score_sum = {1'b0, score_q} + (SCORE_W + 1)'(hit_cnt);

    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    hit_d   = '0;
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_press) begin
          state_d = ST_PLAY;
          score_d = '0;
          lives_d = LIVES_W'(LIVES);
        end
      end
      ST_PLAY: begin
        score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        if (16'(pen_cnt) >= 16'(lives_q)) lives_d = '0;
        else                              lives_d = lives_q - LIVES_W'(pen_cnt);
        // Penalties land before a same-cycle pause; running out of lives beats pausing.
        if (lives_d == '0)    state_d = ST_OVER;
        else if (pause_press) state_d = ST_PAUSE;
        // Hits still score on the way out of PLAY, but the pulse is dropped once keep rises.
        hit_d = (state_d == ST_PLAY) ? hits : '0;
      end
      ST_PAUSE: begin
        if (pause_press) state_d = ST_PLAY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fail_q      <= '0;
      fail_prev_q <= '0;
      hit_q       <= '0;
      score_q     <= '0;
      lives_q     <= LIVES_W'(LIVES);
      keep_q      <= 1'b1;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fail_q      <= fail;
      fail_prev_q <= fail_q;
      hit_q       <= hit_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      keep_q      <= (state_d != ST_PLAY);
      playing_q   <= (state_d == ST_PLAY);
      game_over_q <= (state_d == ST_OVER);
    end
  end

  assign hit       = hit_q;
  assign keep      = keep_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign game_over = game_over_q;
  assign playing   = playing_q;

endmodule

// File: tb/tb_mole_judge.sv
// Directed bench for mole_judge with a short debounce; expected values are hand-derived
// from button-to-press latency of DEBOUNCE+2 and one further cycle into the state/hit flops.
module tb_mole_judge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = '0;
  logic       start_btn = 1'b0;
  logic       pause_btn = 1'b0;
  logic [3:0] mouse = '0;
  logic [3:0] fail = '0;
  logic [3:0] hit;
  logic       keep;
  logic [7:0] score;
  logic [3:0] lives;
  logic       game_over;
  logic       playing;

  int checks = 0;
  int failures = 0;

  logic [3:0] hit_pre, hit_at, hit_post;
  logic       keep_pre, keep_at;

  mole_judge #(.N_HOLES(4), .DEBOUNCE(4), .LIVES(3), .SCORE_W(8)) dut (
    .clk(clk), .rst(rst), .btn(btn), .start_btn(start_btn), .pause_btn(pause_btn),
    .mouse(mouse), .fail(fail), .hit(hit), .keep(keep), .score(score),
    .lives(lives), .game_over(game_over), .playing(playing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise the given buttons at a falling edge, capture hit/keep around the cycle where
  // the registered response lands (7 edges later), then release and let levels settle.
  task automatic press(input logic [3:0] h, input logic s, input logic p);
    btn = h; start_btn = s; pause_btn = p;
    repeat (6) @(negedge clk);
    hit_pre = hit; keep_pre = keep;
    @(negedge clk);
    hit_at = hit; keep_at = keep;
    @(negedge clk);
    hit_post = hit;
    repeat (2) @(negedge clk);
    btn = '0; start_btn = 1'b0; pause_btn = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_keep", keep, 1);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, 3);
    chk("rst_hit", hit, 0);
    chk("rst_over", game_over, 0);
    chk("rst_playing", playing, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Game 1: start, one good hit, glitch, penalties down to OVER
    press(4'b0000, 1'b1, 1'b0);
    chk("start_keep_pre", keep_pre, 1);
    chk("start_keep_at", keep_at, 0);
    chk("start_playing", playing, 1);
    chk("start_score", score, 0);
    chk("start_lives", lives, 3);

    mouse = 4'b0010;
    press(4'b0010, 1'b0, 1'b0);
    chk("hit_pre", hit_pre, 0);
    chk("hit_at", hit_at, 4'b0010);
    chk("hit_post", hit_post, 0);
    chk("hit_score", score, 1);

    mouse = 4'b0000;
    btn[2] = 1'b1;
    repeat (2) @(negedge clk);
    btn[2] = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_lives", lives, 3);
    chk("glitch_score", score, 1);

    press(4'b0001, 1'b0, 1'b0);
    chk("wrong_hit", hit_at, 0);
    chk("wrong_lives", lives, 2);

    fail[3] = 1'b1;
    repeat (3) @(negedge clk);
    chk("miss_lives", lives, 1);
    fail[3] = 1'b0;
    repeat (3) @(negedge clk);
    chk("miss_fall_lives", lives, 1);

    press(4'b1100, 1'b0, 1'b0);
    chk("over_lives", lives, 0);
    chk("over_flag", game_over, 1);
    chk("over_keep", keep, 1);
    chk("over_playing", playing, 0);
    chk("over_score", score, 1);

    // Game 2: restart, pause behaviour
    press(4'b0000, 1'b1, 1'b0);
    chk("restart_score", score, 0);
    chk("restart_lives", lives, 3);
    chk("restart_playing", playing, 1);

    press(4'b0000, 1'b0, 1'b1);
    chk("pause_keep", keep, 1);
    chk("pause_playing", playing, 0);
    mouse = 4'b0010;
    press(4'b0010, 1'b0, 1'b0);
    chk("pause_hit", hit_at, 0);
    chk("pause_score", score, 0);
    fail[0] = 1'b1;
    repeat (4) @(negedge clk);
    chk("pause_miss_lives", lives, 3);
    fail[0] = 1'b0;
    press(4'b0000, 1'b1, 1'b0);
    chk("pause_start_keep", keep, 1);
    press(4'b0000, 1'b0, 1'b1);
    chk("resume_playing", playing, 1);
    chk("resume_score", score, 0);
    chk("resume_lives", lives, 3);

    mouse = 4'b0000;
    press(4'b0001, 1'b0, 1'b1);
    chk("pen_pause_lives", lives, 2);
    chk("pen_pause_keep", keep, 1);
    press(4'b0000, 1'b0, 1'b1);
    chk("pen_resume_playing", playing, 1);

    // Score saturation: 63*4 + 3 = 255, then one more hit
    mouse = 4'b1111;
    for (int k = 0; k < 63; k++) press(4'b1111, 1'b0, 1'b0);
    chk("sat_252", score, 252);
    press(4'b0111, 1'b0, 1'b0);
    chk("sat_255", score, 255);
    press(4'b0001, 1'b0, 1'b0);
    chk("sat_hold", score, 255);
    chk("sat_hit", hit_at, 4'b0001);

    // Losing hit: scores (saturated) but pulse suppressed as OVER is entered
    mouse = 4'b0001;
    press(4'b1111, 1'b0, 1'b0);
    chk("lose_hit", hit_at, 0);
    chk("lose_lives", lives, 0);
    chk("lose_over", game_over, 1);
    chk("lose_score", score, 255);

    press(4'b0000, 1'b1, 1'b0);
    chk("over_start_score", score, 0);
    chk("over_start_lives", lives, 3);
    chk("over_start_over", game_over, 0);

    // Async reset with a hit press already in flight
    mouse = 4'b0010;
    btn = 4'b0010;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    btn = 4'b0000;
    #1;
    chk("arst_hit", hit, 0);
    chk("arst_keep", keep, 1);
    chk("arst_score", score, 0);
    chk("arst_lives", lives, 3);
    chk("arst_playing", playing, 0);
    chk("arst_over", game_over, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("post_rst_hit", hit, 0);
    end
    chk("post_rst_keep", keep, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
